// File: rtl/dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: FSM states and width helpers.
package dot_product_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_FEED,
      ST_DRAIN
   } state_t;

   // Width able to hold the chunk count of the longest legal vector, inclusive.
   function automatic int unsigned chunk_cnt_width(input int unsigned max_total,
                                                   input int unsigned units);
      return $clog2((max_total + units - 1) / units + 1);
   endfunction

   // Width of the partial-chunk remainder (at least one bit).
   function automatic int unsigned rem_width(input int unsigned units);
      return (units > 1) ? $clog2(units) : 1;
   endfunction

endpackage

// File: rtl/dot_product_sequencer_chunk_zero_mask.sv
// Lane enable for a chunk: on the last chunk of a vector whose length is not a
// multiple of the lane count, lanes at or above the remainder are disabled.
module chunk_zero_mask
   import dot_product_sequencer_pkg::*;
#(
   parameter int unsigned no_of_units = 8,
   parameter int unsigned rem_w       = rem_width(no_of_units)
) (
   input  logic [rem_w-1:0]       i_rem,
   input  logic                   i_last,
   output logic [no_of_units-1:0] o_lane_en
);

   // Disable the padding lanes of a partial final chunk.
   always_comb begin
      o_lane_en = '1;
      for (int unsigned i = 0; i < no_of_units; i++) begin
         if (i_last && (i_rem != '0) && (i >= 32'(i_rem))) begin
            o_lane_en[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequencer that fetches both operand vectors chunk by chunk from the operand
// RAMs, feeds them to the dot-product unit and captures the scalar result.
module dot_product_sequencer
   import dot_product_sequencer_pkg::*;
#(
   parameter int unsigned element_width = 32,
   parameter int unsigned no_of_units   = 8,
   parameter int unsigned addr_width    = 10,
   parameter int unsigned max_total     = 256
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [31:0]                           total,
   input  logic [addr_width-1:0]                 base_addr_a,
   input  logic [addr_width-1:0]                 base_addr_b,
   output logic                                  mem_rd_en,
   output logic [addr_width-1:0]                 mem_addr_a,
   output logic [addr_width-1:0]                 mem_addr_b,
   input  logic [element_width*no_of_units-1:0]  mem_data_a,
   input  logic [element_width*no_of_units-1:0]  mem_data_b,
   output logic [element_width*no_of_units-1:0]  dp_first_row,
   output logic [element_width*no_of_units-1:0]  dp_second_row,
   output logic                                  dp_read_now,
   input  logic                                  dp_ready,
   input  logic                                  dp_finish,
   input  logic [element_width-1:0]              dp_result,
   output logic [element_width-1:0]              result,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error
);

   localparam int unsigned DW = element_width * no_of_units;
   localparam int unsigned CW = chunk_cnt_width(max_total, no_of_units);
   localparam int unsigned RW = rem_width(no_of_units);

   state_t                  r_state;
   logic [CW-1:0]           r_k;
   logic [CW-1:0]           r_nchunks;
   logic [RW-1:0]           r_rem;
   logic [addr_width-1:0]   r_base_a;
   logic [addr_width-1:0]   r_base_b;
   logic [addr_width-1:0]   r_addr_a;
   logic [addr_width-1:0]   r_addr_b;
   logic                    r_rd_en;
   logic [DW-1:0]           r_first;
   logic [DW-1:0]           r_second;
   logic [element_width-1:0] r_result;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_error;

   logic [31:0]             w_total_rounded;
   logic [CW-1:0]           w_nchunks;
   logic [RW-1:0]           w_rem;
   logic [CW-1:0]           w_k_next;
   logic                    w_last;
   logic [no_of_units-1:0]  w_lane_en;
   logic [DW-1:0]           w_first_masked;
   logic [DW-1:0]           w_second_masked;

   // Chunk count and remainder of the requested length; only latched when legal.
   assign w_total_rounded = total + 32'(no_of_units - 1);
   assign w_nchunks       = CW'(w_total_rounded / 32'(no_of_units));
   assign w_rem           = RW'(total % 32'(no_of_units));
   assign w_k_next        = r_k + CW'(1);
   assign w_last          = (r_k == r_nchunks - CW'(1));

   chunk_zero_mask #(
      .no_of_units (no_of_units),
      .rem_w       (RW)
   ) u_mask (
      .i_rem     (r_rem),
      .i_last    (w_last),
      .o_lane_en (w_lane_en)
   );

   // Apply the lane enable to both incoming RAM words.
   always_comb begin
      w_first_masked  = '0;
      w_second_masked = '0;
      for (int unsigned i = 0; i < no_of_units; i++) begin
         if (w_lane_en[i]) begin
            w_first_masked[i*element_width +: element_width]  = mem_data_a[i*element_width +: element_width];
            w_second_masked[i*element_width +: element_width] = mem_data_b[i*element_width +: element_width];
         end
      end
   end

   // Job FSM: accept/reject start, fetch, load, feed each chunk, then await the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_nchunks <= '0;
         r_rem     <= '0;
         r_base_a  <= '0;
         r_base_b  <= '0;
         r_addr_a  <= '0;
         r_addr_b  <= '0;
         r_rd_en   <= 1'b0;
         r_first   <= '0;
         r_second  <= '0;
         r_result  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_rd_en <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (total == '0) begin
                     r_result <= '0;
                     r_done   <= 1'b1;
                  end else if (total > 32'(max_total)) begin
                     r_error <= 1'b1;
                  end else begin
                     r_nchunks <= w_nchunks;
                     r_rem     <= w_rem;
                     r_base_a  <= base_addr_a;
                     r_base_b  <= base_addr_b;
                     r_k       <= '0;
                     r_addr_a  <= base_addr_a;
                     r_addr_b  <= base_addr_b;
                     r_rd_en   <= 1'b1;
                     r_busy    <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: r_state <= ST_LOAD;
            ST_LOAD: begin
               r_first  <= w_first_masked;
               r_second <= w_second_masked;
               r_state  <= ST_FEED;
            end
            ST_FEED: begin
               if (dp_ready) begin
                  r_k <= w_k_next;
                  if (w_k_next == r_nchunks) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     // Address for the next fetch is issued together with entry to FETCH.
                     r_addr_a <= r_base_a + addr_width'(w_k_next);
                     r_addr_b <= r_base_b + addr_width'(w_k_next);
                     r_rd_en  <= 1'b1;
                     r_state  <= ST_FETCH;
                  end
               end
            end
            ST_DRAIN: begin
               if (dp_finish) begin
                  r_result <= dp_result;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The chunk strobe follows dp_ready within the FEED cycle so a chunk costs three cycles.
   assign dp_read_now   = (r_state == ST_FEED) && dp_ready;

   assign mem_rd_en     = r_rd_en;
   assign mem_addr_a    = r_addr_a;
   assign mem_addr_b    = r_addr_b;
   assign dp_first_row  = r_first;
   assign dp_second_row = r_second;
   assign result        = r_result;
   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized self-checking bench for dot_product_sequencer with RAM and
// dot-product-unit models and an element-level reference dot product.
module tb_dot_product_sequencer;

   localparam int unsigned EW   = 32;
   localparam int unsigned NU   = 8;
   localparam int unsigned AW   = 10;
   localparam int unsigned MAXT = 256;
   localparam int unsigned DW   = EW * NU;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   total;
   logic [AW-1:0] base_addr_a, base_addr_b;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr_a, mem_addr_b;
   logic [DW-1:0] mem_data_a, mem_data_b;
   logic [DW-1:0] dp_first_row, dp_second_row;
   logic          dp_read_now;
   logic          dp_ready, dp_finish;
   logic [EW-1:0] dp_result;
   logic [EW-1:0] result;
   logic          busy, done, error;

   always #5 clk = ~clk;

   dot_product_sequencer #(
      .element_width (EW),
      .no_of_units   (NU),
      .addr_width    (AW),
      .max_total     (MAXT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .total         (total),
      .base_addr_a   (base_addr_a),
      .base_addr_b   (base_addr_b),
      .mem_rd_en     (mem_rd_en),
      .mem_addr_a    (mem_addr_a),
      .mem_addr_b    (mem_addr_b),
      .mem_data_a    (mem_data_a),
      .mem_data_b    (mem_data_b),
      .dp_first_row  (dp_first_row),
      .dp_second_row (dp_second_row),
      .dp_read_now   (dp_read_now),
      .dp_ready      (dp_ready),
      .dp_finish     (dp_finish),
      .dp_result     (dp_result),
      .result        (result),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   logic [DW-1:0] ram_a [0:(1<<AW)-1];
   logic [DW-1:0] ram_b [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int l = 0; l < NU; l++) w[l*EW +: EW] = $urandom;
      return w;
   endfunction

   // Dot-product unit model: sum of lane products of one chunk.
   function automatic logic [31:0] chunk_dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [31:0] s;
      s = '0;
      for (int l = 0; l < NU; l++) s = s + a[l*EW +: EW] * b[l*EW +: EW];
      return s;
   endfunction

   // Reference: element e of a vector lives in word base+e/NU, lane e%NU.
   function automatic logic [31:0] ref_dot(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                                           input int unsigned n);
      logic [31:0]   s;
      logic [DW-1:0] wa, wb;
      s = '0;
      for (int unsigned e = 0; e < n; e++) begin
         wa = ram_a[AW'(32'(ba) + e / NU)];
         wb = ram_b[AW'(32'(bb) + e / NU)];
         s  = s + wa[(e % NU)*EW +: EW] * wb[(e % NU)*EW +: EW];
      end
      return s;
   endfunction

   // RAM model with one-cycle read latency; garbage when not being read.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_data_a <= ram_a[mem_addr_a];
         mem_data_b <= ram_b[mem_addr_b];
      end else begin
         mem_data_a <= rand_word();
         mem_data_b <= rand_word();
      end
   end

   int            cyc = 0;
   int            n_feed, n_rd, n_done, n_err, last_feed_cyc;
   logic [31:0]   acc;
   logic [AW-1:0] rd_a_q[$], rd_b_q[$];
   logic [DW-1:0] fed_a_q[$], fed_b_q[$];

   // Observe DUT strobes mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (mem_rd_en) begin
         n_rd++;
         rd_a_q.push_back(mem_addr_a);
         rd_b_q.push_back(mem_addr_b);
      end
      if (dp_read_now) begin
         n_feed++;
         acc = acc + chunk_dot(dp_first_row, dp_second_row);
         fed_a_q.push_back(dp_first_row);
         fed_b_q.push_back(dp_second_row);
         last_feed_cyc = cyc;
      end
      if (done)  n_done++;
      if (error) n_err++;
   end

   task automatic clear_mon();
      n_feed = 0; n_rd = 0; n_done = 0; n_err = 0; last_feed_cyc = 0; acc = '0;
      rd_a_q.delete(); rd_b_q.delete(); fed_a_q.delete(); fed_b_q.delete();
   endtask

   task automatic run_job(input string tag, input int unsigned tot, input logic [AW-1:0] ba,
                          input logic [AW-1:0] bb, input bit rand_ready, input bit stall);
      int unsigned   nch, rem, to, sc, dly;
      logic [31:0]   expv;
      logic [DW-1:0] hold_a, hold_b, m;
      nch  = (tot + NU - 1) / NU;
      rem  = tot % NU;
      expv = ref_dot(ba, bb, tot);
      clear_mon();
      dp_ready = stall ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start = 1'b1; total = tot; base_addr_a = ba; base_addr_b = bb;
      sc = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0; total = $urandom; base_addr_a = AW'($urandom); base_addr_b = AW'($urandom);
      chk({tag, "_busy"}, busy, 1);
      if (stall) begin
         repeat (2) @(posedge clk);
         #1;
         hold_a = dp_first_row;
         hold_b = dp_second_row;
         for (int i = 0; i < 10; i++) begin
            dp_finish = (i == 3);
            dp_result = $urandom;
            start     = (i == 5);
            total     = (i == 5) ? 32'd8 : 32'd300;
            @(posedge clk); #1;
         end
         dp_finish = 1'b0;
         start     = 1'b0;
         chk({tag, "_stall_nofeed"}, n_feed, 0);
         chk({tag, "_stall_row_a"}, dp_first_row, hold_a);
         chk({tag, "_stall_row_b"}, dp_second_row, hold_b);
         chk({tag, "_stall_nodone"}, n_done, 0);
         dp_ready = 1'b1;
      end
      to = 0;
      while (n_feed < int'(nch) && to < 3000) begin
         if (rand_ready) dp_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
         to++;
      end
      dp_ready = 1'b1;
      chk({tag, "_feed_timeout"}, (to < 3000), 1);
      dly = $urandom_range(0, 3);
      repeat (dly) begin @(posedge clk); #1; end
      dp_result = acc;
      dp_finish = 1'b1;
      @(posedge clk); #1;
      dp_finish = 1'b0;
      dp_result = $urandom;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_result"}, result, expv);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 0);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_n_done"}, n_done, 1);
      chk({tag, "_n_feed"}, n_feed, nch);
      chk({tag, "_n_rd"}, n_rd, nch);
      chk({tag, "_n_err"}, n_err, 0);
      if (rd_a_q.size() == nch) begin
         for (int unsigned k = 0; k < nch; k++) begin
            chk({tag, "_addr_a"}, rd_a_q[k], AW'(32'(ba) + k));
            chk({tag, "_addr_b"}, rd_b_q[k], AW'(32'(bb) + k));
         end
      end
      if (rem != 0 && fed_a_q.size() == nch) begin
         m = '0;
         for (int unsigned l = rem; l < NU; l++) m[l*EW +: EW] = '1;
         chk({tag, "_pad_a"}, fed_a_q[nch-1] & m, 0);
         chk({tag, "_pad_b"}, fed_b_q[nch-1] & m, 0);
      end
      if (!rand_ready && !stall) chk({tag, "_latency"}, last_feed_cyc - int'(sc), 3 * nch);
   endtask

   task automatic zero_job();
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; total = 0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_result", result, 0);
      chk("zero_busy", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("zero_n_rd", n_rd, 0);
      chk("zero_n_feed", n_feed, 0);
      chk("zero_n_done", n_done, 1);
   endtask

   task automatic over_job(input int unsigned tot);
      logic [31:0] prev;
      prev = result;
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; total = tot;
      @(posedge clk); #1;
      start = 1'b0;
      chk("over_error", error, 1);
      chk("over_busy", busy, 0);
      chk("over_result", result, prev);
      repeat (4) @(posedge clk);
      #1;
      chk("over_n_err", n_err, 1);
      chk("over_n_done", n_done, 0);
      chk("over_n_rd", n_rd, 0);
      chk("over_busy_late", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned to;
      reset = 1'b0; start = 1'b0; total = '0; base_addr_a = '0; base_addr_b = '0;
      dp_ready = 1'b0; dp_finish = 1'b0; dp_result = '0;
      clear_mon();
      for (int i = 0; i < (1 << AW); i++) begin
         ram_a[i] = rand_word();
         ram_b[i] = rand_word();
      end
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_read_now", dp_read_now, 0);
      chk("rst_result", result, 0);
      chk("rst_row_a", dp_first_row, 0);
      chk("rst_row_b", dp_second_row, 0);
      #20;
      @(posedge clk); #1;
      reset = 1'b1;

      ram_a[10]  = {NU{32'd1}};
      ram_a[11]  = {NU{32'd1}};
      ram_b[500] = {NU{32'd2}};
      ram_b[501] = {NU{32'd2}};
      run_job("t16", 16, 10'd10, 10'd500, 1'b0, 1'b0);
      chk("t16_value", result, 32);

      run_job("t13", 13, 10'd1022, 10'd40, 1'b0, 1'b0);
      zero_job();
      run_job("t5", 5, 10'd1023, 10'd7, 1'b0, 1'b0);
      over_job(300);
      over_job(257);
      run_job("stall", 20, 10'd100, 10'd200, 1'b0, 1'b1);
      run_job("max", 256, 10'd1000, 10'd3, 1'b0, 1'b0);

      // Reset while waiting for the datapath result.
      clear_mon();
      dp_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; total = 16; base_addr_a = 10'd5; base_addr_b = 10'd6;
      @(posedge clk); #1;
      start = 1'b0;
      to = 0;
      while (n_feed < 2 && to < 200) begin @(posedge clk); #1; to++; end
      chk("rstd_feed_timeout", (to < 200), 1);
      reset = 1'b0;
      #1;
      chk("rstd_busy", busy, 0);
      chk("rstd_result", result, 0);
      chk("rstd_row_a", dp_first_row, 0);
      chk("rstd_rd_en", mem_rd_en, 0);
      @(posedge clk); #1;
      dp_finish = 1'b1; dp_result = $urandom;
      @(posedge clk); #1;
      dp_finish = 1'b0; reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rstd_no_done", n_done, 0);
      chk("rstd_result_hold", result, 0);
      run_job("after_rst", 8, 10'd77, 10'd78, 1'b0, 1'b0);

      for (int j = 0; j < 16; j++) begin
         run_job("rnd", $urandom_range(1, MAXT), AW'($urandom), AW'($urandom),
                 bit'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
